sdram_read_burst: RTL and testbench

SDRAM_READ_BURST -- requirements
Module: sdram_read_burst

---
 rtl/sdram_pkg.sv | 22 ++
 rtl/sdram_rd_vld_pipe.sv | 40 ++++
 rtl/sdram_read_burst.sv | 209 ++++++++++++++++++++
 tb/tb_sdram_read_burst.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM read-burst engine.
//   - rd_state_e : one-hot FSM state encoding
//   - CMD_*      : {CS,RAS,CAS,WE} command encodings
//   - A10_ALL_BANKS : address bus value for precharge / idle (A10=1)
package sdram_pkg;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_REQ   = 5'b00010,
    ST_ACT   = 5'b00100,
    ST_READ  = 5'b01000,
    ST_PRECH = 5'b10000
  } rd_state_e;

  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;

  localparam logic [12:0] A10_ALL_BANKS = 13'h0400;

endpackage

// File: rtl/sdram_rd_vld_pipe.sv
// Delay line that turns a one-cycle READ-issue pulse into the DQ capture
// strobe: data_vld_o is high for BL cycles starting CL cycles after the
// cycle in which the READ command is visible on the command bus.
// Ports:
//   clk_i      - clock
//   rst_ni     - synchronous active-low reset
//   issue_i    - high in the cycle the READ command register is being loaded
//   data_vld_o - capture strobe
module sdram_rd_vld_pipe
  import sdram_pkg::*;
#(
  parameter int CL = 3,
  parameter int BL = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic issue_i,
  output logic data_vld_o
);

  localparam int DEPTH = CL + BL;

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  // issue_i is sampled at the same edge that loads READ into the command
  // register, so bit k is set exactly k cycles after READ appears.
  assign sr_d = {sr_q[DEPTH-2:0], issue_i};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign data_vld_o = |sr_q[DEPTH-1:CL];

endmodule

// File: rtl/sdram_read_burst.sv
// SDRAM read-burst engine: requests the bus from an arbiter, opens a row,
// issues back-to-back READ bursts, and precharges. A transfer of rd_len
// bursts is split into segments at column wrap or when a refresh is pending.
// Ports:
//   sysclk_100M, rst_n            - clock, synchronous active-low reset
//   rd_start/rd_addr/rd_len       - request (sampled only in IDLE)
//   rd_busy, rd_done              - status
//   arbit_read_req/ack/end        - arbiter handshake
//   refresh_req                   - pending refresh, ends a segment early
//   cmd_reg/sdram_addr/sdram_bank_addr - registered SDRAM command bus
//   data_vld                      - DQ capture strobe
//   dbg_state                     - current FSM state (one-hot)
//
// Arbiter handshake: arbit_read_req is held high for every cycle the FSM
// sits in REQ; a high arbit_read_ack sampled in REQ is the grant and moves
// to ACT on the next edge. arbit_read_end is a one-cycle release pulse in
// the first cycle after the bus is given back (PRECH exit to REQ or IDLE).
module sdram_read_burst
  import sdram_pkg::*;
#(
  parameter int ROW_W  = 13,
  parameter int COL_W  = 9,
  parameter int BANK_W = 2,
  parameter int BL     = 4,
  parameter int CL     = 3,
  parameter int TRCD   = 2,
  parameter int TRP    = 2,
  parameter int LEN_W  = 16
) (
  input  logic                          sysclk_100M,
  input  logic                          rst_n,
  input  logic                          rd_start,
  input  logic [BANK_W+ROW_W+COL_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]              rd_len,
  output logic                          rd_busy,
  output logic                          rd_done,
  output logic                          arbit_read_req,
  input  logic                          arbit_read_ack,
  output logic                          arbit_read_end,
  input  logic                          refresh_req,
  output logic [3:0]                    cmd_reg,
  output logic [12:0]                   sdram_addr,
  output logic [BANK_W-1:0]             sdram_bank_addr,
  output logic                          data_vld,
  output logic [4:0]                    dbg_state
);

  localparam int ADDR_W = BANK_W + ROW_W + COL_W;

  rd_state_e          state_q, state_d;
  logic [3:0]         wait_q, wait_d;
  logic [3:0]         rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   remain_q, remain_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [12:0]        saddr_q, saddr_d;
  logic [BANK_W-1:0]  bank_q, bank_d;
  logic               end_q, end_d;
  logic               done_q, done_d;
  logic               issue;

  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic [BANK_W-1:0]  addr_bank_q;

  assign col_q       = addr_q[COL_W-1:0];
  assign row_q       = addr_q[COL_W +: ROW_W];
  assign addr_bank_q = addr_q[ADDR_W-1 -: BANK_W];

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    rd_cnt_d = rd_cnt_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    issue    = 1'b0;
    end_d    = 1'b0;
    done_d   = 1'b0;
    cmd_d    = CMD_NOP;
    saddr_d  = A10_ALL_BANKS;
    bank_d   = bank_q;

    case (state_q)
      ST_IDLE: begin
        if (rd_start) begin
          state_d  = ST_REQ;
          addr_d   = rd_addr;
          remain_d = (rd_len == '0) ? LEN_W'(1) : rd_len;
        end
      end
      ST_REQ: begin
        if (arbit_read_ack) begin
          state_d = ST_ACT;
          wait_d  = '0;
        end
      end
      ST_ACT: begin
        if (wait_q == 4'(TRCD - 1)) begin
          state_d  = ST_READ;
          rd_cnt_d = '0;
          issue    = 1'b1;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_READ: begin
        if (rd_cnt_q == 4'(BL - 1)) begin
          // Burst boundary. addr_q has already advanced past the last READ,
          // so col==0 here means that READ wrapped the column.
          if ((remain_q == '0) || (col_q == '0) || refresh_req) begin
            state_d = ST_PRECH;
            wait_d  = '0;
          end else begin
            rd_cnt_d = '0;
            issue    = 1'b1;
          end
        end else begin
          rd_cnt_d = rd_cnt_q + 4'd1;
        end
      end
      ST_PRECH: begin
        if (wait_q == 4'(TRP - 1)) begin
          wait_d = '0;
          if (remain_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            end_d   = 1'b1;
          end else if (refresh_req) begin
            state_d = ST_REQ;
            end_d   = 1'b1;
          end else begin
            state_d = ST_ACT;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The flat {bank,row,col} add carries col wrap into row and row wrap
    // into bank; the bank simply rolls over at the top.
    if (issue) begin
      addr_d   = addr_q + ADDR_W'(BL);
      remain_d = remain_q - LEN_W'(1);
    end

    // Command bus is loaded from next-state so it lines up with state_q.
    if (issue) begin
      cmd_d                = CMD_READ;
      saddr_d              = '0;
      saddr_d[COL_W-1:0]   = col_q;
      bank_d               = addr_bank_q;
    end else if ((state_d == ST_ACT) && (state_q != ST_ACT)) begin
      cmd_d                = CMD_ACTIVE;
      saddr_d              = '0;
      saddr_d[ROW_W-1:0]   = row_q;
      bank_d               = addr_bank_q;
    end else if ((state_d == ST_PRECH) && (state_q != ST_PRECH)) begin
      cmd_d                = CMD_PRECHARGE;
    end
  end

  always_ff @(posedge sysclk_100M) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      rd_cnt_q <= '0;
      addr_q   <= '0;
      remain_q <= '0;
      cmd_q    <= CMD_NOP;
      saddr_q  <= A10_ALL_BANKS;
      bank_q   <= '0;
      end_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      rd_cnt_q <= rd_cnt_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      cmd_q    <= cmd_d;
      saddr_q  <= saddr_d;
      bank_q   <= bank_d;
      end_q    <= end_d;
      done_q   <= done_d;
    end
  end

  sdram_rd_vld_pipe #(
    .CL (CL),
    .BL (BL)
  ) u_vld_pipe (
    .clk_i      (sysclk_100M),
    .rst_ni     (rst_n),
    .issue_i    (issue),
    .data_vld_o (data_vld)
  );

  assign rd_busy         = (state_q != ST_IDLE);
  assign arbit_read_req  = (state_q == ST_REQ);
  assign rd_done         = done_q;
  assign arbit_read_end  = end_q;
  assign cmd_reg         = cmd_q;
  assign sdram_addr      = saddr_q;
  assign sdram_bank_addr = bank_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_sdram_read_burst.sv
// Self-checking bench for sdram_read_burst. A transfer-level model turns
// (address, length, refresh point) into the expected list of bus events
// (ACT/READ/PRE commands, release and done pulses) with their spacing; a
// negedge monitor compares every observed event and the data_vld strobe.
module tb_sdram_read_burst;

  localparam int ROW_W  = 13;
  localparam int COL_W  = 9;
  localparam int BANK_W = 2;
  localparam int BL     = 4;
  localparam int CL     = 3;
  localparam int TRCD   = 2;
  localparam int TRP    = 2;
  localparam int LEN_W  = 16;
  localparam int ADDR_W = BANK_W + ROW_W + COL_W;
  localparam int DC     = 255;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_PRE = 4'b0010;

  localparam logic [2:0] K_ACT  = 3'd1;
  localparam logic [2:0] K_READ = 3'd2;
  localparam logic [2:0] K_PRE  = 3'd3;
  localparam logic [2:0] K_END  = 3'd4;
  localparam logic [2:0] K_DONE = 3'd5;
  localparam logic [2:0] K_BAD  = 3'd7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic              rd_start = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [LEN_W-1:0]  rd_len = '0;
  logic              rd_busy, rd_done;
  logic              arbit_read_req, arbit_read_end;
  logic              arbit_read_ack = 1'b0;
  logic              refresh_req = 1'b0;
  logic [3:0]        cmd_reg;
  logic [12:0]       sdram_addr;
  logic [BANK_W-1:0] sdram_bank_addr;
  logic              data_vld;
  logic [4:0]        dbg_state;

  sdram_read_burst #(
    .ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W), .BL(BL), .CL(CL),
    .TRCD(TRCD), .TRP(TRP), .LEN_W(LEN_W)
  ) dut (
    .sysclk_100M     (clk),
    .rst_n           (rst_n),
    .rd_start        (rd_start),
    .rd_addr         (rd_addr),
    .rd_len          (rd_len),
    .rd_busy         (rd_busy),
    .rd_done         (rd_done),
    .arbit_read_req  (arbit_read_req),
    .arbit_read_ack  (arbit_read_ack),
    .arbit_read_end  (arbit_read_end),
    .refresh_req     (refresh_req),
    .cmd_reg         (cmd_reg),
    .sdram_addr      (sdram_addr),
    .sdram_bank_addr (sdram_bank_addr),
    .data_vld        (data_vld),
    .dbg_state       (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [25:0] exp_q[$];   // {gap[7:0], kind[2:0], bank[1:0], addr[12:0]}
  int rd_cyc_q[$];
  bit mon_en = 1'b0;
  int rd_seen = 0;
  int last_ev_cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [25:0] mk_ev(input logic [2:0] kind, input int bank,
                                        input int addr, input int gap);
    return {8'(gap), kind, 2'(bank), 13'(addr)};
  endfunction

  // Transfer-level model: walk the bursts, split segments by the rules
  // (all issued / column wrap / refresh at this burst's boundary).
  task automatic build_exp(input int bank, input int row, input int col,
                           input int len, input int ref_after);
    int b, r, c, rem, bi, gap_act;
    bit fin, pre, first;
    b = bank; r = row; c = col;
    rem = (len == 0) ? 1 : len;
    bi = 0; fin = 1'b0; gap_act = DC;
    while (!fin) begin
      exp_q.push_back(mk_ev(K_ACT, b, r, gap_act));
      first = 1'b1;
      pre = 1'b0;
      do begin
        exp_q.push_back(mk_ev(K_READ, b, c, first ? TRCD : BL));
        first = 1'b0;
        c = c + BL;
        if (c >= (1 << COL_W)) begin
          c = 0;
          r = r + 1;
          if (r >= (1 << ROW_W)) begin
            r = 0;
            b = (b + 1) % (1 << BANK_W);
          end
        end
        rem--;
        bi++;
        pre = (bi == ref_after);
      end while (!(rem == 0 || c == 0 || pre));
      exp_q.push_back(mk_ev(K_PRE, 0, 'h400, BL));
      if (rem == 0) begin
        exp_q.push_back(mk_ev(K_DONE, 0, 0, TRP));
        fin = 1'b1;
      end else if (pre) begin
        exp_q.push_back(mk_ev(K_END, 0, 0, TRP));
        gap_act = DC;
      end else begin
        gap_act = TRP;
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic [25:0] mon_ev, mon_e;
  bit mon_have, mon_exp_v;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_have = 1'b1;
      mon_ev = '0;
      if (cmd_reg == C_ACT)      mon_ev = mk_ev(K_ACT, int'(sdram_bank_addr), int'(sdram_addr), 0);
      else if (cmd_reg == C_RD)  mon_ev = mk_ev(K_READ, int'(sdram_bank_addr), int'(sdram_addr), 0);
      else if (cmd_reg == C_PRE) mon_ev = mk_ev(K_PRE, 0, int'(sdram_addr), 0);
      else if (cmd_reg != C_NOP) mon_ev = mk_ev(K_BAD, 0, int'(cmd_reg), 0);
      else if (rd_done) begin
        mon_ev = mk_ev(K_DONE, 0, 0, 0);
        check_val("end_with_done", 32'(arbit_read_end), 32'd1);
      end else if (arbit_read_end) mon_ev = mk_ev(K_END, 0, 0, 0);
      else mon_have = 1'b0;

      if (mon_have) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_event", 32'(mon_ev[17:0]), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("event", 32'(mon_ev[17:0]), 32'(mon_e[17:0]));
          if (mon_e[25:18] != 8'(DC))
            check_val("gap", 32'(cyc - last_ev_cyc), 32'(mon_e[25:18]));
        end
        last_ev_cyc = cyc;
        if (mon_ev[17:15] == K_READ) begin
          rd_seen++;
          rd_cyc_q.push_back(cyc);
        end
      end

      while (rd_cyc_q.size() > 0 && (cyc - rd_cyc_q[0]) > CL + BL)
        void'(rd_cyc_q.pop_front());
      mon_exp_v = 1'b0;
      foreach (rd_cyc_q[i])
        if ((cyc - rd_cyc_q[i]) >= CL && (cyc - rd_cyc_q[i]) <= CL + BL - 1)
          mon_exp_v = 1'b1;
      check_val("data_vld", 32'(data_vld), 32'(mon_exp_v));
    end
  end

  // ---------------- driver ----------------
  task automatic run_xfer(input int bank, input int row, input int col, input int len,
                          input int ref_after, input int ack_dly, input bit poke_start);
    int waitc, n;
    bit ref_up, got_done;
    waitc = 0; n = 0; ref_up = 1'b0; got_done = 1'b0;
    build_exp(bank, row, col, len, ref_after);
    rd_seen = 0;
    @(negedge clk); #1;
    rd_start = 1'b1;
    rd_addr  = {2'(bank), 13'(row), 9'(col)};
    rd_len   = 16'(len);
    @(negedge clk); #1;
    rd_start = 1'b0;
    check_val("busy_after_start", 32'(rd_busy), 32'd1);
    while (!got_done && n < 1000) begin
      if (arbit_read_req) begin
        if (ref_up) refresh_req = 1'b0;
        if (waitc >= ack_dly) arbit_read_ack = 1'b1;
        else waitc++;
      end else begin
        arbit_read_ack = 1'b0;
        waitc = 0;
      end
      if (ref_after != 0 && !ref_up && rd_seen == ref_after) begin
        refresh_req = 1'b1;
        ref_up = 1'b1;
      end
      if (poke_start && n == 6) begin
        rd_start = 1'b1;
        rd_addr  = ADDR_W'($urandom);
      end else begin
        rd_start = 1'b0;
      end
      @(negedge clk); #1;
      n++;
      if (rd_done) got_done = 1'b1;
    end
    check_val("done_seen", 32'(got_done), 32'd1);
    check_val("busy_low_at_done", 32'(rd_busy), 32'd0);
    refresh_req = 1'b0;
    arbit_read_ack = 1'b0;
    rd_start = 1'b0;
    repeat (CL + BL + 2) @(negedge clk);
    #1;
    check_val("exp_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- main ----------------
  initial begin
    int len, col, row, bank, ref_after, n;
    bit saw;

    repeat (3) @(negedge clk);
    #1;
    check_val("rst_state", 32'(dbg_state), 32'h01);
    check_val("rst_cmd", 32'(cmd_reg), 32'(C_NOP));
    check_val("rst_addr", 32'(sdram_addr), 32'h400);
    check_val("rst_bank", 32'(sdram_bank_addr), 32'd0);
    check_val("rst_busy", 32'(rd_busy), 32'd0);
    check_val("rst_vld", 32'(data_vld), 32'd0);
    check_val("rst_req", 32'(arbit_read_req), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    run_xfer(0, 0, 0, 1, 0, 0, 1'b0);            // single burst, immediate ack
    run_xfer(0, 0, 0, 3, 0, 0, 1'b0);            // three bursts in one row
    run_xfer(1, 5, 'h1F8, 3, 0, 0, 1'b0);        // column wrap into next row
    run_xfer(2, 9, 'h10, 4, 2, 1, 1'b0);         // refresh during burst 2
    run_xfer(3, 'h1FFF, 'h1FC, 2, 0, 0, 1'b0);   // bank wraps to 0
    run_xfer(0, 7, 'h1FC, 3, 1, 2, 1'b0);        // refresh and wrap coincide
    run_xfer(1, 3, 'h20, 0, 0, 0, 1'b1);         // len 0, start ignored while busy

    // Reset in the middle of READ: transfer is abandoned silently.
    mon_en = 1'b0;
    @(negedge clk); #1;
    rd_start = 1'b1; rd_addr = '0; rd_len = 16'd4; arbit_read_ack = 1'b1;
    @(negedge clk); #1;
    rd_start = 1'b0;
    n = 0;
    while (cmd_reg != C_RD && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check_val("reached_read", 32'(cmd_reg), 32'(C_RD));
    rst_n = 1'b0;
    @(negedge clk); #1;
    check_val("mid_rst_state", 32'(dbg_state), 32'h01);
    check_val("mid_rst_cmd", 32'(cmd_reg), 32'(C_NOP));
    check_val("mid_rst_vld", 32'(data_vld), 32'd0);
    check_val("mid_rst_busy", 32'(rd_busy), 32'd0);
    check_val("mid_rst_addr", 32'(sdram_addr), 32'h400);
    rst_n = 1'b1;
    arbit_read_ack = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk); #1;
      if (rd_done || arbit_read_end || data_vld) saw = 1'b1;
    end
    check_val("no_done_after_rst", 32'(saw), 32'd0);
    rd_cyc_q.delete();
    exp_q.delete();
    mon_en = 1'b1;

    for (int t = 0; t < 25; t++) begin
      len  = $urandom_range(0, 6);
      bank = $urandom_range(0, 3);
      row  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 8191) : 8191;
      col  = ($urandom_range(0, 1) == 1) ? 4 * $urandom_range(0, 127)
                                         : 512 - 4 * $urandom_range(1, 3);
      ref_after = ($urandom_range(0, 1) == 1) ? $urandom_range(1, (len == 0) ? 1 : len) : 0;
      run_xfer(bank, row, col, len, ref_after, $urandom_range(0, 3),
               $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
